// File: rtl/line_window_buffer_pkg.sv
`default_nettype none
// line_window_pkg -- limits and helpers shared by the line window buffer (rev 1.0)
package line_window_pkg;

  localparam int MAX_LINES = 4;

  function automatic bit lines_legal(input int n);
    return (n >= 1) && (n <= MAX_LINES);
  endfunction

  // Low bit of slice k in a packed column of k-indexed pixels
  function automatic int slice_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_window_buffer_bank.sv
`default_nettype none
// line_window_bank -- one simple-dual-port line RAM, read-first, registered read (rev 1.0)
module line_window_bank #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset, so the column output is clean out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// line_window_buffer -- keeps the last NUM_LINES lines and emits a vertical pixel column (rev 1.0)
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LINES  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_sof,
  input  logic                              in_eol,
  input  logic                              clr_err,
  output logic                              out_valid,
  output logic [DATA_WIDTH*(NUM_LINES+1)-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]             out_col,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              out_rows_ok,
  output logic [ADDR_WIDTH:0]               line_len,
  output logic                              ovf_err
);

  localparam int PTR_W  = $clog2(MAX_LINES);
  localparam int FILL_W = $clog2(MAX_LINES + 1);
  localparam logic [ADDR_WIDTH-1:0] COL_MAX   = '1;
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(NUM_LINES - 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(NUM_LINES);

  generate
    if (!lines_legal(NUM_LINES)) begin : g_bad_num_lines
      $error("line_window_buffer: NUM_LINES must be 1..%0d", MAX_LINES);
    end
  endgenerate

  logic [ADDR_WIDTH-1:0]           col, cur_col, col_nxt;
  logic                            col_full, cur_full, full_nxt;
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [FILL_W-1:0]               lines_filled, fill_base, fill_nxt;
  logic                            wr_en;
  logic [DATA_WIDTH-1:0]           cur_pix;
  logic [NUM_LINES*DATA_WIDTH-1:0] bank_q;

  // col_full marks that the last column has been written on this line;
  // further non-sof pixels are overflow and must not touch the RAM.
  always_comb begin
    cur_col   = in_sof ? '0 : col;
    cur_full  = in_sof ? 1'b0 : col_full;
    fill_base = in_sof ? '0 : lines_filled;
    wr_en     = in_valid && !cur_full;
    col_nxt   = cur_col + 1'b1;
    full_nxt  = 1'b0;
    if (in_eol) begin
      col_nxt = '0;
    end else if (cur_col == COL_MAX) begin
      col_nxt  = COL_MAX;
      full_nxt = 1'b1;
    end
    fill_nxt = fill_base;
    if (in_eol && (fill_base < FILL_FULL)) fill_nxt = fill_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      col_full     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lines_filled <= '0;
      line_len     <= '0;
      cur_pix      <= '0;
      out_valid    <= 1'b0;
      out_col      <= '0;
      out_sof      <= 1'b0;
      out_eol      <= 1'b0;
      out_rows_ok  <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        col          <= col_nxt;
        col_full     <= full_nxt;
        lines_filled <= fill_nxt;
        rd_ptr       <= wr_ptr;
        cur_pix      <= in_data;
        out_col      <= cur_col;
        out_sof      <= in_sof;
        out_eol      <= in_eol;
        out_rows_ok  <= (fill_base == FILL_FULL);
        if (in_eol) begin
          wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
          line_len <= {1'b0, cur_col} + 1'b1;
        end
      end
      if (in_valid && cur_full) ovf_err <= 1'b1;
      else if (clr_err)         ovf_err <= 1'b0;
    end
  end

  generate
    for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
      line_window_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (wr_ptr == PTR_W'(b))),
        .wr_addr (cur_col),
        .wr_data (in_data),
        .rd_en   (in_valid),
        .rd_addr (cur_col),
        .rd_data (bank_q[b*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // Line-k of the column sits in bank (ptr - k) mod NUM_LINES, ptr as seen at read time
  function automatic int bank_of(input logic [PTR_W-1:0] ptr, input int k);
    int b;
    b = int'(ptr) - k;
    if (b < 0) b = b + NUM_LINES;
    return b;
  endfunction

  always_comb begin
    out_data = '0;
    out_data[DATA_WIDTH-1:0] = cur_pix;
    for (int k = 1; k <= NUM_LINES; k++) begin
      out_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] =
        bank_q[slice_lo(bank_of(rd_ptr, k), DATA_WIDTH) +: DATA_WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// tb_line_window_buffer -- table-driven and randomized checks against a line-history model (rev 1.0)
module tb_line_window_buffer;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int COLS = 16;
  localparam int MAXL = 256;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_sof, in_eol, clr_err;
  logic [DW-1:0] in_data;

  logic          a_valid, a_sof, a_eol, a_rows, a_ovf;
  logic [23:0]   a_data;
  logic [AW-1:0] a_col;
  logic [AW:0]   a_len;
  logic          b_valid, b_sof, b_eol, b_rows, b_ovf;
  logic [31:0]   b_data;
  logic [AW-1:0] b_col;
  logic [AW:0]   b_len;

  always #5 clk = ~clk;

  line_window_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_eol(in_eol), .clr_err(clr_err), .out_valid(a_valid), .out_data(a_data),
    .out_col(a_col), .out_sof(a_sof), .out_eol(a_eol), .out_rows_ok(a_rows),
    .line_len(a_len), .ovf_err(a_ovf)
  );

  line_window_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_eol(in_eol), .clr_err(clr_err), .out_valid(b_valid), .out_data(b_data),
    .out_col(b_col), .out_sof(b_sof), .out_eol(b_eol), .out_rows_ok(b_rows),
    .line_len(b_len), .ovf_err(b_ovf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: every line since reset is remembered; the bank slot of a line is its index mod N,
  // so line-k at column c is the newest write at c among lines in the slot of (L-k).
  int  hist [2][MAXL][COLS];
  int  mdl_L [2], mdl_n [2], mdl_fill [2], mdl_len [2];
  bit  mdl_ovf [2];
  bit  pv;
  int  pd [2][4];
  int  pcol [2];
  bit  psof [2], peol [2], prows [2];

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      mdl_L[m] = 0; mdl_n[m] = 0; mdl_fill[m] = 0; mdl_len[m] = 0; mdl_ovf[m] = 1'b0;
      for (int j = 0; j < MAXL; j++)
        for (int c = 0; c < COLS; c++) hist[m][j][c] = -1;
    end
  endtask

  function automatic int older(input int m, input int k, input int c, input int nl);
    for (int j = mdl_L[m]; j >= 0; j--)
      if (((mdl_L[m] - j) % nl) == (k % nl) && hist[m][j][c] >= 0) return hist[m][j][c];
    return -1;
  endfunction

  task automatic model_pixel(input int m, input bit v, input logic [7:0] d,
                             input bit sof, input bit eol, input bit clr);
    int  nl = (m != 0) ? 3 : 2;
    int  c;
    bit  over;
    if (!v) begin
      if (clr) mdl_ovf[m] = 1'b0;
      return;
    end
    if (sof) begin mdl_n[m] = 0; mdl_fill[m] = 0; end
    over     = (mdl_n[m] >= COLS);
    c        = over ? COLS - 1 : mdl_n[m];
    pcol[m]  = c;
    psof[m]  = sof;
    peol[m]  = eol;
    prows[m] = (mdl_fill[m] == nl);
    pd[m][0] = int'(d);
    for (int k = 1; k < 4; k++) pd[m][k] = (k <= nl && !over) ? older(m, k, c, nl) : -1;
    if (!over) hist[m][mdl_L[m]][c] = int'(d);
    mdl_ovf[m] = over ? 1'b1 : (clr ? 1'b0 : mdl_ovf[m]);
    if (eol) begin
      mdl_len[m] = over ? COLS : mdl_n[m] + 1;
      mdl_L[m]++;
      if (mdl_fill[m] < nl) mdl_fill[m]++;
      mdl_n[m] = 0;
    end else begin
      mdl_n[m]++;
    end
  endtask

  task automatic check_dut(input int m);
    logic ov, osof, oeol, orow, oovf;
    logic [31:0]   od;
    logic [AW-1:0] ocol;
    logic [AW:0]   olen;
    int    nl  = (m != 0) ? 3 : 2;
    string tag = (m != 0) ? "B" : "A";
    if (m == 0) begin
      ov = a_valid; od = {8'h00, a_data}; ocol = a_col; osof = a_sof; oeol = a_eol;
      orow = a_rows; olen = a_len; oovf = a_ovf;
    end else begin
      ov = b_valid; od = b_data; ocol = b_col; osof = b_sof; oeol = b_eol;
      orow = b_rows; olen = b_len; oovf = b_ovf;
    end
    chk({tag, ".valid"}, 64'(ov), 64'(pv));
    if (pv) begin
      for (int k = 0; k <= nl; k++)
        if (pd[m][k] >= 0) chk($sformatf("%s.slice%0d", tag, k), 64'(od[k*8 +: 8]), 64'(pd[m][k]));
      chk({tag, ".col"},  64'(ocol), 64'(pcol[m]));
      chk({tag, ".sof"},  64'(osof), 64'(psof[m]));
      chk({tag, ".eol"},  64'(oeol), 64'(peol[m]));
      chk({tag, ".rows"}, 64'(orow), 64'(prows[m]));
    end
    chk({tag, ".line_len"}, 64'(olen), 64'(mdl_len[m]));
    chk({tag, ".ovf_err"},  64'(oovf), 64'(mdl_ovf[m]));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit sof, input bit eol, input bit clr);
    in_valid = v; in_data = d; in_sof = sof; in_eol = eol; clr_err = clr;
    pv = v;
    for (int m = 0; m < 2; m++) model_pixel(m, v, d, sof, eol, clr);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) check_dut(m);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".A.valid"}, 64'(a_valid), 64'd0);
    chk({tag, ".A.data"},  64'(a_data),  64'd0);
    chk({tag, ".A.col"},   64'(a_col),   64'd0);
    chk({tag, ".A.flags"}, 64'({a_sof, a_eol, a_rows, a_ovf}), 64'd0);
    chk({tag, ".A.len"},   64'(a_len),   64'd0);
    chk({tag, ".B.valid"}, 64'(b_valid), 64'd0);
    chk({tag, ".B.data"},  64'(b_data),  64'd0);
    chk({tag, ".B.col"},   64'(b_col),   64'd0);
    chk({tag, ".B.flags"}, 64'({b_sof, b_eol, b_rows, b_ovf}), 64'd0);
    chk({tag, ".B.len"},   64'(b_len),   64'd0);
  endtask

  typedef struct {
    bit          sof;
    bit          eol;
    logic [7:0]  d;
    int          col;
    bit          rows;
    logic [23:0] data;
    logic [23:0] mask;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int r, c, i, len;
    bit s;

    // three 4-pixel lines, pixel = row*16+col
    for (r = 0; r < 3; r++) begin
      for (c = 0; c < 4; c++) begin
        i = r * 4 + c;
        tbl[i].sof  = (i == 0);
        tbl[i].eol  = (c == 3);
        tbl[i].d    = 8'(r * 16 + c);
        tbl[i].col  = c;
        tbl[i].rows = (r == 2);
        tbl[i].data = {8'((r - 2) * 16 + c), 8'((r - 1) * 16 + c), 8'(r * 16 + c)};
        tbl[i].mask = {(r == 2) ? 8'hFF : 8'h00, (r >= 1) ? 8'hFF : 8'h00, 8'hFF};
      end
    end

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_eol = 1'b0; clr_err = 1'b0;
    pv = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].d, tbl[i].sof, tbl[i].eol, 1'b0);
      chk($sformatf("tbl%0d.col", i),  64'(a_col), 64'(tbl[i].col));
      chk($sformatf("tbl%0d.rows", i), 64'(a_rows), 64'(tbl[i].rows));
      chk($sformatf("tbl%0d.data", i), 64'(a_data & tbl[i].mask), 64'(tbl[i].data & tbl[i].mask));
    end
    chk("tbl.line_len", 64'(a_len), 64'd4);

    // ten back-to-back 8-pixel lines
    for (r = 0; r < 10; r++)
      for (c = 0; c < 8; c++) step(1'b1, 8'($urandom), 1'b0, c == 7, 1'b0);

    // 20-pixel line on a 16-column buffer
    for (i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b0, i == 19, 1'b0);
      chk($sformatf("ovf.err%0d", i), 64'(a_ovf), 64'(i >= 16));
      chk($sformatf("ovf.col%0d", i), 64'(a_col), 64'((i < 15) ? i : 15));
    end
    chk("ovf.line_len", 64'(a_len), 64'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf.cleared", 64'(a_ovf), 64'd0);
    for (i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, i == 15, 1'b0);
    chk("full16.ovf", 64'(a_ovf), 64'd0);
    chk("full16.len", 64'(a_len), 64'd16);

    // sof mid-frame: rows_ok drops for two lines
    for (r = 0; r < 3; r++) begin
      for (c = 0; c < 5; c++) begin
        step(1'b1, 8'($urandom), (r == 0) && (c == 0), c == 4, 1'b0);
        chk($sformatf("sof.rows%0d_%0d", r, c), 64'(a_rows), 64'(r == 2));
      end
    end
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    chk("single.len", 64'(a_len), 64'd1);
    chk("single.rows", 64'(a_rows), 64'd0);

    // reset asserted at col 7 of the third line
    for (r = 0; r < 3; r++)
      for (c = 0; c < ((r == 2) ? 7 : 10); c++) step(1'b1, 8'($urandom), 1'b0, (r < 2) && (c == 9), 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_zero("midreset");
    clear_model();
    pv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("postreset.col", 64'(a_col), 64'd0);
    chk("postreset.rows", 64'(a_rows), 64'd0);

    // random lines with ~50% idle cycles carrying junk controls
    for (r = 0; r < 40; r++) begin
      len = $urandom_range(1, 20);
      s   = ($urandom_range(0, 7) == 0);
      for (c = 0; c < len; c++) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++)
          step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        step(1'b1, 8'($urandom), s && (c == 0), c == len - 1, $urandom_range(0, 15) == 0);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised multi-line video buffer: stores the last NUM_LINES lines of a pixel stream in internal simple-dual-port RAM banks and emits, per input pixel, a vertical column of NUM_LINES+1 pixels (current plus the same column of each previous line). Sits between the video input/scaler path and 2-D filter or scaler kernels. Replaces fixed 2048x24 single-line buffers. Adds rotating bank pointers, line tracking and overflow detection.

## Interface
- DATA_WIDTH, 24, bits per pixel
- ADDR_WIDTH, 11, log2 of maximum line length (depth 2^ADDR_WIDTH)
- NUM_LINES, 2, stored previous lines, legal 1..4
- clk  in  1  single clock for all logic and RAM
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel strobe; no backpressure
- in_data  in  DATA_WIDTH  pixel
- in_sof  in  1  qualifies first pixel of frame
- in_eol  in  1  qualifies last pixel of line
- clr_err  in  1  clears ovf_err
- out_valid  out  1  column strobe
- out_data  out  DATA_WIDTH*(NUM_LINES+1)  slice k = pixel from line-k (k=0 current, LSBs)
- out_col  out  ADDR_WIDTH  column index of out_data
- out_sof, out_eol  out  1 each  in_sof/in_eol delayed with data
- out_rows_ok  out  1  all NUM_LINES previous lines belong to current frame
- line_len  out  ADDR_WIDTH+1  pixel count of last completed line
- ovf_err  out  1  sticky: a line exceeded 2^ADDR_WIDTH pixels

## Operation
- NUM_LINES banks, each 2^ADDR_WIDTH x DATA_WIDTH, read-first on same-address read/write.
- wr_ptr (0..NUM_LINES-1) selects the bank holding line-NUM_LINES; line-k lives in bank (wr_ptr-k) mod NUM_LINES... for k=NUM_LINES this is wr_ptr itself.
- On in_valid: all banks read at col; bank wr_ptr written with in_data at col (old content read out first as line-NUM_LINES).
- col: 0 at reset; +1 per in_valid; forced to 0 for a pixel carrying in_sof; reset to 0 after in_eol.
- On in_valid&in_eol: wr_ptr advances mod NUM_LINES; line_len <= col+1; lines_filled <= min(lines_filled+1, NUM_LINES).
- On in_valid&in_sof: lines_filled <= 0 (then eol rule applies if both set: 1-pixel line gives lines_filled=1).
- out_rows_ok = (lines_filled == NUM_LINES), sampled with the pixel.
- Overflow: pixel arriving with col == 2^ADDR_WIDTH-1 already written and not eol: no RAM write, col holds, ovf_err set; out_data slices for such pixels are don't-care; line_len saturates at 2^ADDR_WIDTH.
- ovf_err cleared by clr_err; set wins over simultaneous clear.
- Short line after longer line: unwritten columns keep stale data; no clearing.
- in_valid low: no state change, no RAM access.

## Timing
- Latency 1 cycle: out_valid/out_data/out_col/out_sof/out_eol/out_rows_ok reflect pixel accepted previous edge.
- Throughput 1 pixel/clk sustained, including across eol and sof.
- Reset values: all outputs 0; col, wr_ptr, lines_filled, line_len 0. RAM contents not cleared.
- Reset asserted mid-line: everything above returns to reset immediately; first post-reset pixel writes col 0 bank 0.

## Structure
- Package line_window_pkg: MAX_LINES=4, legality check function for NUM_LINES, slice-index helper for out_data.
- Sub-module line_window_bank: one SDP RAM bank, read-first, registered read, 1-cycle latency; instantiated NUM_LINES times via generate.
- Top: col/ptr/fill counters, output rotation mux (registered wr_ptr copy selects banks), current-pixel delay register.

## Test plan
- NUM_LINES=2, three 4-pixel lines, pixel = row*16+col, sof on first: third line col 2 -> out_data {0x02,0x12,0x22}, out_rows_ok=1; line 2 outputs out_rows_ok=0.
- Continuous 10 lines at 1 pixel/clk: wr_ptr wraps 0,1,0...; every column shows line-1, line-2 values exactly; no gaps in out_valid.
- ADDR_WIDTH=4, 20-pixel line: ovf_err=1 from pixel 17, line_len=16, col holds 15; clr_err -> 0; next 16-pixel line no error.
- sof mid-frame after 5 lines: out_rows_ok=0 for next 2 lines, 1 on third; sof+eol on single pixel: line_len=1.
- rst_n low at col 7 of line 3: all outputs 0 next cycle; after release first pixel out_col=0, out_rows_ok=0.
- in_valid gaps (random 50%): output sequence identical to gap-free run, latency exactly 1 per pixel.
